// File: rtl/ddr_arb_pkg.sv
// Shared IDs, FSM encodings and constants for the DDR AXI port arbiter.
package ddr_arb_pkg;

   localparam logic [3:0] ID_W0 = 4'h0;
   localparam logic [3:0] ID_W1 = 4'h1;
   localparam logic [3:0] ID_R0 = 4'h2;
   localparam logic [3:0] ID_R1 = 4'h3;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_ADDR = 1'b1
   } rd_state_e;

   // Wide enough for any realistic AXI data width; the top slices what it needs.
   localparam int WSTRB_MAX_W = 128;
   localparam logic [WSTRB_MAX_W-1:0] WSTRB_ALL = {WSTRB_MAX_W{1'b1}};

endpackage

// File: rtl/ddr_axi_arb_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the requester that wins a tie
// and moves to the other requester whenever the owner reports it was served.
module rr_arb2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served,
   output logic       grant,
   output logic       valid
);

   logic ptr_r;

   // Priority pointer, requester 0 first out of reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_r <= 1'b0;
      end else if (update) begin
         ptr_r <= ~served;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Grant the pointed-to requester if it asks, otherwise the other one.
   always_comb begin
      valid = |req;
      if (req[ptr_r]) begin
         grant = ptr_r;
      end else begin
         grant = ~ptr_r;
      end
   end

endmodule

// File: rtl/ddr_axi_arb.sv
// Shares one DDR controller AXI port between two writers and two readers;
// write and read sides are arbitrated independently, each round-robin.
module ddr_axi_arb
   import ddr_arb_pkg::*;
#(
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int DATA_WIDTH      = 256
) (
   input  logic                       ddr_clk,
   input  logic                       ddr_rstn,
   input  logic                       w0_req,
   input  logic [CTRL_ADDR_WIDTH-1:0] w0_addr,
   input  logic [3:0]                 w0_len,
   output logic                       w0_ack,
   input  logic [DATA_WIDTH-1:0]      w0_data,
   output logic                       w0_wready,
   output logic                       w0_wlast,
   input  logic                       w1_req,
   input  logic [CTRL_ADDR_WIDTH-1:0] w1_addr,
   input  logic [3:0]                 w1_len,
   output logic                       w1_ack,
   input  logic [DATA_WIDTH-1:0]      w1_data,
   output logic                       w1_wready,
   output logic                       w1_wlast,
   input  logic                       r0_req,
   input  logic [CTRL_ADDR_WIDTH-1:0] r0_addr,
   input  logic [3:0]                 r0_len,
   output logic                       r0_ack,
   output logic                       r0_rvalid,
   output logic                       r0_rlast,
   output logic [DATA_WIDTH-1:0]      r0_rdata,
   input  logic                       r1_req,
   input  logic [CTRL_ADDR_WIDTH-1:0] r1_addr,
   input  logic [3:0]                 r1_len,
   output logic                       r1_ack,
   output logic                       r1_rvalid,
   output logic                       r1_rlast,
   output logic [DATA_WIDTH-1:0]      r1_rdata,
   output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
   output logic [3:0]                 axi_awuser_id,
   output logic [3:0]                 axi_awlen,
   output logic                       axi_awvalid,
   input  logic                       axi_awready,
   output logic [DATA_WIDTH-1:0]      axi_wdata,
   output logic [DATA_WIDTH/8-1:0]    axi_wstrb,
   input  logic                       axi_wready,
   input  logic                       axi_wusero_last,
   output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
   output logic [3:0]                 axi_aruser_id,
   output logic [3:0]                 axi_arlen,
   output logic                       axi_arvalid,
   input  logic                       axi_arready,
   input  logic [DATA_WIDTH-1:0]      axi_rdata,
   input  logic [3:0]                 axi_rid,
   input  logic                       axi_rlast,
   input  logic                       axi_rvalid
);

   wr_state_e  wr_state_r, wr_state_s;
   rd_state_e  rd_state_r, rd_state_s;
   logic       wr_gnt_r;
   logic       rd_gnt_r;
   logic [1:0] outstanding_r;
   logic [1:0] rd_elig_s;
   logic       w_pick_s, w_any_s, r_pick_s, r_any_s;
   logic       w_load_s, aw_hs_s, in_data_s, w_done_s;
   logic       r_load_s, ar_hs_s;

   rr_arb2 u_wr_arb (
      .clk    (ddr_clk),
      .rstn   (ddr_rstn),
      .req    ({w1_req, w0_req}),
      .update (w_done_s),
      .served (wr_gnt_r),
      .grant  (w_pick_s),
      .valid  (w_any_s)
   );

   // A reader with a burst still in flight may not issue another AR.
   assign rd_elig_s = {r1_req & ~outstanding_r[1], r0_req & ~outstanding_r[0]};

   rr_arb2 u_rd_arb (
      .clk    (ddr_clk),
      .rstn   (ddr_rstn),
      .req    (rd_elig_s),
      .update (ar_hs_s),
      .served (rd_gnt_r),
      .grant  (r_pick_s),
      .valid  (r_any_s)
   );

   assign w_load_s  = (wr_state_r == W_IDLE) & w_any_s;
   assign aw_hs_s   = (wr_state_r == W_ADDR) & axi_awready;
   assign in_data_s = (wr_state_r == W_DATA);
   assign w_done_s  = in_data_s & axi_wready & axi_wusero_last;
   assign r_load_s  = (rd_state_r == R_IDLE) & r_any_s;
   assign ar_hs_s   = (rd_state_r == R_ADDR) & axi_arready;

   // Write FSM state register.
   always_ff @(posedge ddr_clk) begin
      if (!ddr_rstn) begin
         wr_state_r <= W_IDLE;
      end else begin
         wr_state_r <= wr_state_s;
      end
   end

   // Write FSM next state.
   always_comb begin
      wr_state_s = wr_state_r;
      case (wr_state_r)
         W_IDLE: begin
            if (w_any_s) wr_state_s = W_ADDR;
            else         wr_state_s = W_IDLE;
         end
         W_ADDR: begin
            if (axi_awready) wr_state_s = W_DATA;
            else             wr_state_s = W_ADDR;
         end
         W_DATA: begin
            if (axi_wready && axi_wusero_last) wr_state_s = W_IDLE;
            else                               wr_state_s = W_DATA;
         end
         default: wr_state_s = W_IDLE;
      endcase
   end

   // AW channel registers, loaded at grant and held until the handshake.
   always_ff @(posedge ddr_clk) begin
      if (!ddr_rstn) begin
         axi_awaddr    <= '0;
         axi_awlen     <= 4'd0;
         axi_awuser_id <= 4'h0;
         axi_awvalid   <= 1'b0;
         wr_gnt_r      <= 1'b0;
      end else if (w_load_s) begin
         axi_awaddr    <= w_pick_s ? w1_addr : w0_addr;
         axi_awlen     <= w_pick_s ? w1_len : w0_len;
         axi_awuser_id <= w_pick_s ? ID_W1 : ID_W0;
         axi_awvalid   <= 1'b1;
         wr_gnt_r      <= w_pick_s;
      end else if (aw_hs_s) begin
         axi_awvalid   <= 1'b0;
      end
   end

   assign w0_ack    = aw_hs_s & ~wr_gnt_r;
   assign w1_ack    = aw_hs_s & wr_gnt_r;
   assign axi_wdata = wr_gnt_r ? w1_data : w0_data;
   assign axi_wstrb = WSTRB_ALL[DATA_WIDTH/8-1:0];
   assign w0_wready = in_data_s & axi_wready & ~wr_gnt_r;
   assign w1_wready = in_data_s & axi_wready & wr_gnt_r;
   assign w0_wlast  = w0_wready & axi_wusero_last;
   assign w1_wlast  = w1_wready & axi_wusero_last;

   // Read FSM state register.
   always_ff @(posedge ddr_clk) begin
      if (!ddr_rstn) begin
         rd_state_r <= R_IDLE;
      end else begin
         rd_state_r <= rd_state_s;
      end
   end

   // Read FSM next state.
   always_comb begin
      rd_state_s = rd_state_r;
      case (rd_state_r)
         R_IDLE: begin
            if (r_any_s) rd_state_s = R_ADDR;
            else         rd_state_s = R_IDLE;
         end
         R_ADDR: begin
            if (axi_arready) rd_state_s = R_IDLE;
            else             rd_state_s = R_ADDR;
         end
         default: rd_state_s = R_IDLE;
      endcase
   end

   // AR channel registers, loaded at grant and held until the handshake.
   always_ff @(posedge ddr_clk) begin
      if (!ddr_rstn) begin
         axi_araddr    <= '0;
         axi_arlen     <= 4'd0;
         axi_aruser_id <= 4'h0;
         axi_arvalid   <= 1'b0;
         rd_gnt_r      <= 1'b0;
      end else if (r_load_s) begin
         axi_araddr    <= r_pick_s ? r1_addr : r0_addr;
         axi_arlen     <= r_pick_s ? r1_len : r0_len;
         axi_aruser_id <= r_pick_s ? ID_R1 : ID_R0;
         axi_arvalid   <= 1'b1;
         rd_gnt_r      <= r_pick_s;
      end else if (ar_hs_s) begin
         axi_arvalid   <= 1'b0;
      end
   end

   assign r0_ack    = ar_hs_s & ~rd_gnt_r;
   assign r1_ack    = ar_hs_s & rd_gnt_r;
   assign r0_rvalid = axi_rvalid & (axi_rid == ID_R0);
   assign r1_rvalid = axi_rvalid & (axi_rid == ID_R1);
   assign r0_rlast  = r0_rvalid & axi_rlast;
   assign r1_rlast  = r1_rvalid & axi_rlast;
   assign r0_rdata  = axi_rdata;
   assign r1_rdata  = axi_rdata;

   // In-flight flags: set on AR handshake, cleared by that reader's last beat.
   always_ff @(posedge ddr_clk) begin
      if (!ddr_rstn) begin
         outstanding_r <= 2'b00;
      end else begin
         outstanding_r[0] <= (ar_hs_s & ~rd_gnt_r) | (outstanding_r[0] & ~r0_rlast);
         outstanding_r[1] <= (ar_hs_s & rd_gnt_r) | (outstanding_r[1] & ~r1_rlast);
      end
   end

endmodule

// File: tb/tb_ddr_axi_arb.sv
// Directed plus randomized bench for ddr_axi_arb; the bench plays the DDR
// controller and predicts grants/routing from the arbitration rules.
module tb_ddr_axi_arb;

   logic         ddr_clk, ddr_rstn;
   logic         w0_req, w1_req, r0_req, r1_req;
   logic [27:0]  w0_addr, w1_addr, r0_addr, r1_addr;
   logic [3:0]   w0_len, w1_len, r0_len, r1_len;
   logic         w0_ack, w1_ack, r0_ack, r1_ack;
   logic [255:0] w0_data, w1_data, r0_rdata, r1_rdata;
   logic         w0_wready, w0_wlast, w1_wready, w1_wlast;
   logic         r0_rvalid, r0_rlast, r1_rvalid, r1_rlast;
   logic [27:0]  axi_awaddr, axi_araddr;
   logic [3:0]   axi_awuser_id, axi_awlen, axi_aruser_id, axi_arlen, axi_rid;
   logic         axi_awvalid, axi_awready, axi_arvalid, axi_arready;
   logic [255:0] axi_wdata, axi_rdata;
   logic [31:0]  axi_wstrb;
   logic         axi_wready, axi_wusero_last, axi_rlast, axi_rvalid;

   int checks = 0;
   int failures = 0;
   int abort_beat = -1;
   int conc_beat = -1;
   int ar_seen = 0;
   int wpref;

   ddr_axi_arb #(.CTRL_ADDR_WIDTH(28), .DATA_WIDTH(256)) dut (
      .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn),
      .w0_req(w0_req), .w0_addr(w0_addr), .w0_len(w0_len), .w0_ack(w0_ack),
      .w0_data(w0_data), .w0_wready(w0_wready), .w0_wlast(w0_wlast),
      .w1_req(w1_req), .w1_addr(w1_addr), .w1_len(w1_len), .w1_ack(w1_ack),
      .w1_data(w1_data), .w1_wready(w1_wready), .w1_wlast(w1_wlast),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_len(r0_len), .r0_ack(r0_ack),
      .r0_rvalid(r0_rvalid), .r0_rlast(r0_rlast), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_len(r1_len), .r1_ack(r1_ack),
      .r1_rvalid(r1_rvalid), .r1_rlast(r1_rlast), .r1_rdata(r1_rdata),
      .axi_awaddr(axi_awaddr), .axi_awuser_id(axi_awuser_id), .axi_awlen(axi_awlen),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last),
      .axi_araddr(axi_araddr), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid)
   );

   initial begin
      ddr_clk = 1'b0;
      forever #5 ddr_clk = ~ddr_clk;
   end

   task automatic cyc();
      @(posedge ddr_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // Round-robin rule: a tie goes to the preferred writer, otherwise the sole requester.
   function automatic int pick(input logic a0, input logic a1, input int prefer);
      if (a0 && a1) return prefer;
      return a1 ? 1 : 0;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_awvalid"}, axi_awvalid, 1'b0);
      chk({tag, "_arvalid"}, axi_arvalid, 1'b0);
      chk({tag, "_awaddr"}, axi_awaddr, 28'h0);
      chk({tag, "_awlen"}, axi_awlen, 4'h0);
      chk({tag, "_awid"}, axi_awuser_id, 4'h0);
      chk({tag, "_araddr"}, axi_araddr, 28'h0);
      chk({tag, "_arlen"}, axi_arlen, 4'h0);
      chk({tag, "_arid"}, axi_aruser_id, 4'h0);
      chk({tag, "_acks"}, {w0_ack, w1_ack, r0_ack, r1_ack}, 4'h0);
      chk({tag, "_wready"}, {w0_wready, w1_wready}, 2'b00);
   endtask

   task automatic serve_write(input int who, input int aw_delay, input bit drop);
      int n, beat, beats, guard;
      logic lst;
      logic [3:0] len_e;
      logic [27:0] addr_e;
      len_e  = who ? w1_len : w0_len;
      addr_e = who ? w1_addr : w0_addr;
      beats  = int'(len_e) + 1;
      n = 0;
      while (!axi_awvalid && n < 10) begin cyc(); n++; end
      chk("aw_valid", axi_awvalid, 1'b1);
      chk("aw_id", axi_awuser_id, 4'(who));
      chk("aw_addr", axi_awaddr, addr_e);
      chk("aw_len", axi_awlen, len_e);
      repeat (aw_delay) begin
         chk("ack_early", {w0_ack, w1_ack}, 2'b00);
         cyc();
         chk("aw_hold", axi_awvalid, 1'b1);
      end
      axi_awready = 1'b1;
      #1;
      chk("ack_own", who ? w1_ack : w0_ack, 1'b1);
      chk("ack_other", who ? w0_ack : w1_ack, 1'b0);
      cyc();
      axi_awready = 1'b0;
      if (drop) begin
         if (who == 1) w1_req = 1'b0;
         else          w0_req = 1'b0;
      end
      chk("aw_drop", axi_awvalid, 1'b0);
      beat = 0;
      guard = 0;
      while (beat < beats && guard < 100) begin
         if (beat == abort_beat) begin
            ddr_rstn = 1'b0;
            axi_wready = 1'b1;
            abort_beat = -1;
            cyc();
            check_reset_outputs("rst_mid");
            axi_wready = 1'b0;
            return;
         end
         axi_wready = (conc_beat >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         lst = axi_wready && (beat == beats - 1);
         axi_wusero_last = lst;
         w0_data = rnd256();
         w1_data = rnd256();
         if (conc_beat >= 0 && beat == conc_beat) r1_req = 1'b1;
         axi_arready = (conc_beat >= 0) && axi_arvalid && r1_req;
         #1;
         if (axi_wready) begin
            chk("wdata", axi_wdata, who ? w1_data : w0_data);
            chk("wready_own", who ? w1_wready : w0_wready, 1'b1);
            chk("wready_other", who ? w0_wready : w1_wready, 1'b0);
            chk("wlast", who ? w1_wlast : w0_wlast, lst);
            beat++;
         end else begin
            chk("wready_stall", {w0_wready, w1_wready}, 2'b00);
         end
         if (axi_arready) begin
            chk("conc_r1_ack", r1_ack, 1'b1);
            chk("conc_arid", axi_aruser_id, 4'h3);
            ar_seen++;
         end
         cyc();
         if (axi_arready) begin
            axi_arready = 1'b0;
            r1_req = 1'b0;
         end
         guard++;
      end
      axi_wready = 1'b0;
      axi_wusero_last = 1'b0;
      chk("w_beats", beat, beats);
   endtask

   task automatic serve_ar(input int who, input int delay);
      int n;
      n = 0;
      while (!axi_arvalid && n < 10) begin cyc(); n++; end
      chk("ar_valid", axi_arvalid, 1'b1);
      chk("ar_id", axi_aruser_id, 4'(2 + who));
      chk("ar_addr", axi_araddr, who ? r1_addr : r0_addr);
      chk("ar_len", axi_arlen, who ? r1_len : r0_len);
      repeat (delay) begin cyc(); chk("ar_hold", axi_arvalid, 1'b1); end
      axi_arready = 1'b1;
      #1;
      chk("rack_own", who ? r1_ack : r0_ack, 1'b1);
      chk("rack_other", who ? r0_ack : r1_ack, 1'b0);
      cyc();
      axi_arready = 1'b0;
      if (who == 1) r1_req = 1'b0;
      else          r0_req = 1'b0;
      chk("ar_drop", axi_arvalid, 1'b0);
   endtask

   task automatic return_read(input int who, input int beats, input bit noar);
      int beat, guard;
      logic lst;
      logic [3:0] rid_e;
      rid_e = 4'(2 + who);
      beat = 0;
      guard = 0;
      while (beat < beats && guard < 100) begin
         axi_rvalid = ($urandom_range(0, 3) != 0);
         axi_rid = rid_e;
         axi_rdata = rnd256();
         lst = axi_rvalid && (beat == beats - 1);
         axi_rlast = lst;
         #1;
         chk("r0_route", r0_rvalid, axi_rvalid && (rid_e == 4'h2));
         chk("r1_route", r1_rvalid, axi_rvalid && (rid_e == 4'h3));
         if (axi_rvalid) begin
            chk("rdata", who ? r1_rdata : r0_rdata, axi_rdata);
            chk("rlast_own", who ? r1_rlast : r0_rlast, lst);
            chk("rlast_other", who ? r0_rlast : r1_rlast, 1'b0);
            beat++;
         end
         if (noar) chk("no_ar", axi_arvalid, 1'b0);
         cyc();
         guard++;
      end
      axi_rvalid = 1'b0;
      axi_rlast = 1'b0;
      chk("r_beats", beat, beats);
   endtask

   initial begin
      {w0_req, w1_req, r0_req, r1_req} = 4'h0;
      {w0_addr, w1_addr, r0_addr, r1_addr} = '0;
      {w0_len, w1_len, r0_len, r1_len} = '0;
      w0_data = '0; w1_data = '0; axi_rdata = '0; axi_rid = 4'h0;
      {axi_awready, axi_arready, axi_wready, axi_wusero_last, axi_rlast, axi_rvalid} = 6'h0;
      ddr_rstn = 1'b0;
      cyc(); cyc();
      check_reset_outputs("rst0");
      chk("wstrb", axi_wstrb, 32'hFFFF_FFFF);
      ddr_rstn = 1'b1;
      cyc();

      // Single w0 burst, awready two cycles late.
      w0_addr = 28'h0000100; w0_len = 4'd7; w0_req = 1'b1;
      #1 chk("aw_lat0", axi_awvalid, 1'b0);
      cyc();
      chk("aw_lat1", axi_awvalid, 1'b1);
      serve_write(0, 2, 1'b1);
      axi_wready = 1'b1;
      #1 chk("wready_idle", {w0_wready, w1_wready}, 2'b00);
      cyc();
      axi_wready = 1'b0;

      // Both writers held for four bursts from a fresh pointer.
      ddr_rstn = 1'b0; cyc(); ddr_rstn = 1'b1;
      w0_addr = 28'h0001000; w0_len = 4'd3;
      w1_addr = 28'h0802000; w1_len = 4'd2;
      w0_req = 1'b1; w1_req = 1'b1;
      wpref = 0;
      for (int b = 0; b < 4; b++) begin
         int exp_w;
         exp_w = pick(w0_req, w1_req, wpref);
         serve_write(exp_w, int'($urandom_range(0, 2)), 1'b0);
         wpref = 1 - exp_w;
      end
      w0_req = 1'b0; w1_req = 1'b0;
      cyc(); cyc();
      chk("aw_quiet", axi_awvalid, 1'b0);

      // Randomized writer arrivals.
      for (int it = 0; it < 10; it++) begin
         int exp_w;
         if (!w0_req && $urandom_range(0, 1) == 1) begin
            w0_req = 1'b1; w0_addr = 28'($urandom()); w0_len = 4'($urandom_range(0, 15));
         end
         if (!w1_req && $urandom_range(0, 1) == 1) begin
            w1_req = 1'b1; w1_addr = 28'($urandom()); w1_len = 4'($urandom_range(0, 15));
         end
         if (!w0_req && !w1_req) begin
            w0_req = 1'b1; w0_addr = 28'($urandom()); w0_len = 4'($urandom_range(0, 15));
         end
         exp_w = pick(w0_req, w1_req, wpref);
         serve_write(exp_w, int'($urandom_range(0, 3)), 1'b1);
         wpref = 1 - exp_w;
      end
      while (w0_req || w1_req) begin
         int exp_w;
         exp_w = pick(w0_req, w1_req, wpref);
         serve_write(exp_w, 0, 1'b1);
         wpref = 1 - exp_w;
      end

      // Two readers; data comes back r1 first, then r0.
      r0_addr = 28'h0100040; r0_len = 4'd5;
      r1_addr = 28'h0200080; r1_len = 4'd3;
      r0_req = 1'b1; r1_req = 1'b1;
      serve_ar(0, 1);
      serve_ar(1, 0);
      r0_addr = 28'h0300000; r0_len = 4'd1; r0_req = 1'b1;
      repeat (3) begin cyc(); chk("ar_blocked", axi_arvalid, 1'b0); end
      axi_rvalid = 1'b1; axi_rid = 4'h7; axi_rlast = 1'b1; axi_rdata = rnd256();
      #1 chk("unk_rid", {r0_rvalid, r1_rvalid}, 2'b00);
      cyc();
      axi_rvalid = 1'b0; axi_rlast = 1'b0;
      cyc(); cyc();
      chk("unk_rid_flag", axi_arvalid, 1'b0);
      return_read(1, 4, 1'b1);
      return_read(0, 6, 1'b1);
      // Flag clears one cycle after rlast, AR registers the cycle after that.
      cyc();
      chk("ar_after_rlast", axi_arvalid, 1'b1);
      chk("ar_after_rlast_id", axi_aruser_id, 4'h2);
      serve_ar(0, 0);
      return_read(0, 2, 1'b0);

      // Write burst with an r1 read slipped in at beat 3.
      r1_addr = 28'h0440000; r1_len = 4'd2;
      w0_addr = 28'h0050000; w0_len = 4'd7; w0_req = 1'b1;
      conc_beat = 3;
      ar_seen = 0;
      serve_write(0, 1, 1'b1);
      conc_beat = -1;
      chk("conc_ar_seen", ar_seen, 1);
      return_read(1, 3, 1'b0);

      // Reset during beat 4 of a write, then a fresh w1 burst.
      w0_addr = 28'h0060000; w0_len = 4'd7; w0_req = 1'b1;
      abort_beat = 4;
      serve_write(0, 0, 1'b1);
      ddr_rstn = 1'b1;
      w0_req = 1'b0;
      w1_addr = 28'h0070000; w1_len = 4'd3; w1_req = 1'b1;
      serve_write(1, 1, 1'b1);

      cyc(); cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
